// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed reconfigurable FIR.
// Contents: FSM state enum, sample period constant, accumulator width
// derivation and a generic signed saturation helper.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // 12 MHz clock / 600 kHz sample strobe
    localparam int unsigned CLK_PER_SAMPLE = 20;

    // Widest value the saturation helper operates on
    localparam int unsigned SAT_W = 64;

    // Accumulator wide enough that summing num_tap full-scale products cannot overflow
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned coef_w,
                                              input int unsigned num_tap);
        return in_w + coef_w + $clog2(num_tap);
    endfunction

    // Clamp a signed value into the range of an out_w-bit signed number
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                         input int unsigned out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/reconf_fir_tdm_if.sv
// Sample, coefficient-RAM and status signals of reconf_fir_tdm.
// master: sample source / host side (drives the i* signals)
// slave : filter side (drives the o* signals)
interface reconf_fir_tdm_if #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned ADDR_W = 6
);
    logic                     iEnSample600k;
    logic                     iCoeffUpdateFlag;
    logic                     iCsnRam;
    logic                     iWrnRam;
    logic [ADDR_W-1:0]        iAddrRam;
    logic [COEF_W-1:0]        iWtDtRam;
    logic signed [IN_W-1:0]   iFirIn;
    logic [COEF_W-1:0]        oRdDtRam;
    logic signed [OUT_W-1:0]  oFirOut;
    logic                     oFirValid;
    logic                     oBusy;
    logic                     oOverrun;
    logic                     oSwapPend;

    modport master (
        output iEnSample600k, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam, iFirIn,
        input  oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun, oSwapPend
    );

    modport slave (
        input  iEnSample600k, iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam, iFirIn,
        output oRdDtRam, oFirOut, oFirValid, oBusy, oOverrun, oSwapPend
    );
endinterface

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient store: host writes land in the shadow bank,
// the MAC and host readback see the active bank. A falling edge of the
// update flag arms a shadow->active copy that the FSM triggers at the next
// accepted sample.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   update_flag       host update window (writes allowed while high)
//   csn, wrn          active-low chip select / write enable
//   addr, wdata       coefficient index and write data
//   swap_req          sample accepted in IDLE; applies an armed swap
//   tap               MAC tap index
//   rdata             registered readback of the active bank
//   swap_pend         swap armed, not yet applied
//   coef_c            active coefficient for the current tap (combinational)
module fir_coeff_bank #(
    parameter int unsigned NUM_TAP = 10,
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TAP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_flag,
    input  logic              csn,
    input  logic              wrn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [COEF_W-1:0] wdata,
    input  logic              swap_req,
    input  logic [TAP_W-1:0]  tap,
    output logic [COEF_W-1:0] rdata,
    output logic              swap_pend,
    output logic [COEF_W-1:0] coef_c
);

    logic [COEF_W-1:0] shadow [NUM_TAP];
    logic [COEF_W-1:0] active [NUM_TAP];
    logic              flag_q;
    logic              pend;
    logic [COEF_W-1:0] rdata_q;
    logic [TAP_W-1:0]  addr_idx_c;
    logic              addr_ok_c;
    logic              wr_c;
    logic              rd_c;
    logic              fall_c;
    logic              apply_c;

    // Address decode and swap qualification
    always_comb begin
        addr_idx_c = addr[TAP_W-1:0];
        addr_ok_c  = (addr < ADDR_W'(NUM_TAP));
        wr_c       = !csn && !wrn && update_flag && addr_ok_c;
        rd_c       = !csn && wrn;
        fall_c     = flag_q && !update_flag;
        apply_c    = swap_req && pend;
    end

    // Bank storage, swap arming and readback register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_TAP); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            flag_q  <= 1'b0;
            pend    <= 1'b0;
            rdata_q <= '0;
        end else begin
            flag_q <= update_flag;
            if (wr_c) begin
                shadow[addr_idx_c] <= wdata;
            end
            if (apply_c) begin
                active <= shadow;
            end
            // A new falling edge wins over a swap consumed in the same cycle
            if (fall_c) begin
                pend <= 1'b1;
            end else if (apply_c) begin
                pend <= 1'b0;
            end
            if (rd_c) begin
                rdata_q <= addr_ok_c ? active[addr_idx_c] : '0;
            end
        end
    end

    assign rdata     = rdata_q;
    assign swap_pend = pend;
    assign coef_c    = active[tap];

endmodule

// File: rtl/reconf_fir_tdm.sv
// Reconfigurable FIR with one time-multiplexed MAC: each accepted sample
// shifts the delay line, then NUM_TAP cycles of multiply-accumulate, then a
// saturated, shifted result is published with a one-cycle valid pulse.
// Ports:
//   iClk12M  12 MHz clock
//   iRst     synchronous active-high reset
//   bus      sample strobe/input, coefficient RAM port, output and status
module reconf_fir_tdm
    import fir_pkg::*;
#(
    parameter int unsigned NUM_TAP = 10,
    parameter int unsigned IN_W    = 3,
    parameter int unsigned COEF_W  = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned SHIFT   = 0
) (
    input  logic             iClk12M,
    input  logic             iRst,
    reconf_fir_tdm_if.slave  bus
);

    localparam int unsigned ACC_W  = acc_width(IN_W, COEF_W, NUM_TAP);
    localparam int unsigned PROD_W = IN_W + COEF_W;
    localparam int unsigned TAP_W  = $clog2(NUM_TAP);

    if (NUM_TAP < 2 || NUM_TAP + 2 > CLK_PER_SAMPLE) begin : g_bad_cfg
        $error("NUM_TAP out of range for the sample period");
    end

    fir_state_e                state;
    fir_state_e                state_next;
    logic signed [IN_W-1:0]    x_line      [NUM_TAP];
    logic signed [IN_W-1:0]    x_line_next [NUM_TAP];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic [TAP_W-1:0]          tap;
    logic [TAP_W-1:0]          tap_next;
    logic signed [OUT_W-1:0]   fir_out;
    logic signed [OUT_W-1:0]   fir_out_next;
    logic                      valid;
    logic                      valid_next;
    logic                      busy;
    logic                      busy_next;
    logic                      overrun;
    logic                      overrun_next;
    logic                      swap_req_c;
    logic signed [COEF_W-1:0]  coef_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   shifted_c;

    fir_coeff_bank #(
        .NUM_TAP (NUM_TAP),
        .COEF_W  (COEF_W),
        .ADDR_W  (ADDR_W),
        .TAP_W   (TAP_W)
    ) u_coeff_bank (
        .clk         (iClk12M),
        .rst         (iRst),
        .update_flag (bus.iCoeffUpdateFlag),
        .csn         (bus.iCsnRam),
        .wrn         (bus.iWrnRam),
        .addr        (bus.iAddrRam),
        .wdata       (bus.iWtDtRam),
        .swap_req    (swap_req_c),
        .tap         (tap),
        .rdata       (bus.oRdDtRam),
        .swap_pend   (bus.oSwapPend),
        .coef_c      (coef_c)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_next   = state;
        x_line_next  = x_line;
        acc_next     = acc;
        tap_next     = tap;
        fir_out_next = fir_out;
        valid_next   = 1'b0;
        overrun_next = 1'b0;
        swap_req_c   = 1'b0;
        prod_c       = PROD_W'(x_line[tap]) * PROD_W'(coef_c);
        shifted_c    = acc >>> SHIFT;

        case (state)
            IDLE: begin
                if (bus.iEnSample600k) begin
                    swap_req_c     = 1'b1;
                    x_line_next[0] = bus.iFirIn;
                    for (int k = 1; k < int'(NUM_TAP); k++) begin
                        x_line_next[k] = x_line[k-1];
                    end
                    acc_next   = '0;
                    tap_next   = '0;
                    state_next = MAC;
                end
            end
            MAC: begin
                acc_next     = acc + ACC_W'(prod_c);
                overrun_next = bus.iEnSample600k;
                if (tap == TAP_W'(NUM_TAP - 1)) begin
                    state_next = DONE;
                end else begin
                    tap_next = tap + TAP_W'(1);
                end
            end
            DONE: begin
                fir_out_next = OUT_W'(saturate(SAT_W'(shifted_c), OUT_W));
                valid_next   = 1'b1;
                overrun_next = bus.iEnSample600k;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state <= IDLE;
            for (int k = 0; k < int'(NUM_TAP); k++) begin
                x_line[k] <= '0;
            end
            acc     <= '0;
            tap     <= '0;
            fir_out <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            x_line  <= x_line_next;
            acc     <= acc_next;
            tap     <= tap_next;
            fir_out <= fir_out_next;
            valid   <= valid_next;
            busy    <= busy_next;
            overrun <= overrun_next;
        end
    end

    assign bus.oFirOut   = fir_out;
    assign bus.oFirValid = valid;
    assign bus.oBusy     = busy;
    assign bus.oOverrun  = overrun;

endmodule

// File: tb/tb_reconf_fir_tdm.sv
// Self-checking bench for reconf_fir_tdm: a behavioural model of the
// coefficient banks and delay line predicts each result when the strobe is
// driven; a monitor compares value and latency whenever oFirValid pulses.
`timescale 1ns/1ps
module tb_reconf_fir_tdm;

    localparam int unsigned NUM_TAP = 10;
    localparam int unsigned IN_W    = 3;
    localparam int unsigned COEF_W  = 16;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned SHIFT   = 0;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;

    int          m_act [NUM_TAP];
    int          m_sh  [NUM_TAP];
    int          m_x   [NUM_TAP];
    bit          m_pend;
    bit          m_flag;
    logic [15:0] exp_q [$];
    int          cyc_q [$];

    reconf_fir_tdm_if #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    reconf_fir_tdm #(
        .NUM_TAP (NUM_TAP),
        .IN_W    (IN_W),
        .COEF_W  (COEF_W),
        .OUT_W   (OUT_W),
        .ADDR_W  (ADDR_W),
        .SHIFT   (SHIFT)
    ) dut (
        .iClk12M (clk),
        .iRst    (rst),
        .bus     (bus)
    );

    always #42 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_out();
        longint s = 0;
        for (int k = 0; k < int'(NUM_TAP); k++) s += longint'(m_x[k] * m_act[k]);
        s = s >>> SHIFT;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_flag(input logic v);
        @(posedge clk); #1;
        if (m_flag && !v) m_pend = 1'b1;
        m_flag = v;
        bus.iCoeffUpdateFlag = v;
    endtask

    task automatic ram_write(input int a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0;
        bus.iAddrRam = ADDR_W'(a); bus.iWtDtRam = d;
        if (m_flag && a < int'(NUM_TAP)) m_sh[a] = int'($signed(d));
        @(posedge clk); #1;
        bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
    endtask

    task automatic ram_read(input string tag, input int a, input logic [15:0] exp);
        @(posedge clk); #1;
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iAddrRam = ADDR_W'(a);
        @(posedge clk); #1;
        chk(tag, 32'(bus.oRdDtRam), 32'(exp));
        bus.iCsnRam = 1'b1;
    endtask

    task automatic write_all(input logic [15:0] base, input logic [15:0] step);
        set_flag(1'b1);
        for (int k = 0; k < int'(NUM_TAP); k++) ram_write(k, base + 16'(k) * step);
    endtask

    // One strobe; drop=1 means the DUT is expected to reject it as an overrun
    task automatic strobe(input logic [IN_W-1:0] x, input bit drop, input bit fall);
        @(posedge clk); #1;
        bus.iFirIn = x;
        bus.iEnSample600k = 1'b1;
        if (fall) bus.iCoeffUpdateFlag = 1'b0;
        if (!drop) begin
            if (m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            for (int k = int'(NUM_TAP) - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = int'($signed(x));
            exp_q.push_back(model_out());
            cyc_q.push_back(cyc);
        end
        if (fall && m_flag) m_pend = 1'b1;
        if (fall) m_flag = 1'b0;
        @(posedge clk); #1;
        bus.iEnSample600k = 1'b0;
        if (drop) chk("overrun_pulse", 32'(bus.oOverrun), 32'd1);
    endtask

    task automatic sample(input logic [IN_W-1:0] x);
        strobe(x, 1'b0, 1'b0);
        wait_cyc(NUM_TAP + 2);
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(NUM_TAP); k++) begin
            m_act[k] = 0; m_sh[k] = 0; m_x[k] = 0;
        end
        m_pend = 1'b0;
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_fir_out",   32'($unsigned(bus.oFirOut)), 32'd0);
        chk("rst_fir_valid", 32'(bus.oFirValid), 32'd0);
        chk("rst_busy",      32'(bus.oBusy), 32'd0);
        chk("rst_overrun",   32'(bus.oOverrun), 32'd0);
        chk("rst_swap_pend", 32'(bus.oSwapPend), 32'd0);
        chk("rst_rd_data",   32'(bus.oRdDtRam), 32'd0);
    endtask

    // Scoreboard: compare every published result against the queued prediction
    always @(negedge clk) begin
        if (bus.oFirValid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("fir_out", 32'($unsigned(bus.oFirOut)), 32'(exp_q.pop_front()));
                chk("latency", 32'(cyc - cyc_q.pop_front()), 32'(NUM_TAP + 2));
            end
        end
    end

    initial begin
        #(84 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        rst = 1'b1;
        bus.iEnSample600k = 1'b0; bus.iCoeffUpdateFlag = 1'b0;
        bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
        bus.iAddrRam = '0; bus.iWtDtRam = '0; bus.iFirIn = '0;
        m_flag = 1'b0;
        model_reset();
        wait_cyc(3); #1;
        rst = 1'b0;
        check_reset_outputs();

        // Impulse response through freshly swapped coefficients
        write_all(16'h0A01, 16'h0001);
        ram_write(12, 16'hBEEF);
        set_flag(1'b0);
        @(posedge clk); #1;
        chk("swap_armed", 32'(bus.oSwapPend), 32'd1);
        ram_read("read_before_swap", 3, 16'h0000);
        strobe(3'b001, 1'b0, 1'b0);
        chk("busy_in_mac", 32'(bus.oBusy), 32'd1);
        chk("swap_applied", 32'(bus.oSwapPend), 32'd0);
        wait_cyc(NUM_TAP + 2);
        for (int i = 0; i < int'(NUM_TAP); i++) sample(3'b000);

        // Readback and ignored write outside the update window
        ram_read("read_addr3", 3, 16'h0A04);
        ram_read("read_addr12", 12, 16'h0000);
        ram_write(3, 16'h1234);
        set_flag(1'b1);
        set_flag(1'b0);
        sample(3'b000);
        ram_read("read_after_ignored_wr", 3, 16'h0A04);

        // Saturation at both rails
        write_all(16'h7FFF, 16'h0000);
        set_flag(1'b0);
        for (int i = 0; i < 11; i++) sample(3'b011);
        for (int i = 0; i < 11; i++) sample(3'b100);

        // Live swap: flag falls while the MAC runs on the old bank
        write_all(16'h0001, 16'h0000);
        set_flag(1'b0);
        sample(3'b001);
        write_all(16'h0002, 16'h0000);
        strobe(3'b010, 1'b0, 1'b0);
        wait_cyc(3);
        set_flag(1'b0);
        @(posedge clk); #1;
        chk("swap_pend_mid_mac", 32'(bus.oSwapPend), 32'd1);
        wait_cyc(NUM_TAP);
        sample(3'b010);
        chk("swap_pend_cleared", 32'(bus.oSwapPend), 32'd0);

        // Overrun: second strobe five cycles into the MAC is dropped
        v0 = valid_cnt;
        strobe(3'b011, 1'b0, 1'b0);
        wait_cyc(3);
        strobe(3'b001, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("overrun_clear", 32'(bus.oOverrun), 32'd0);
        wait_cyc(NUM_TAP + 2);
        chk("overrun_valid_count", 32'(valid_cnt - v0), 32'd1);
        sample(3'b000);

        // Strobe coincident with the flag falling edge: swap waits one sample
        write_all(16'h0003, 16'h0000);
        strobe(3'b001, 1'b0, 1'b1);
        chk("same_cycle_swap_armed", 32'(bus.oSwapPend), 32'd1);
        wait_cyc(NUM_TAP + 2);
        sample(3'b001);

        // Reset at MAC tap 4 with a swap armed
        strobe(3'b011, 1'b0, 1'b0);
        set_flag(1'b1);
        set_flag(1'b0);
        wait_cyc(2); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs();
        v0 = valid_cnt;
        wait_cyc(NUM_TAP + 4);
        chk("no_valid_after_reset", 32'(valid_cnt - v0), 32'd0);
        write_all(16'h0A01, 16'h0001);
        set_flag(1'b0);
        sample(3'b001);
        sample(3'b000);

        wait_cyc(4);
        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
